// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory, zero-fills the rest, then releases the CPU.
module imem_loader #(
  parameter int XLEN = 32,
  parameter int PC_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               in_ready,
  input  logic               load_start,
  output logic               imem_we,
  output logic [PC_BITS-1:0] imem_waddr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);
  localparam int DEPTH = 2**PC_BITS;
  localparam logic [1:0] HDR = 2'd0, DATA = 2'd1, FILL = 2'd2, DONE = 2'd3;
  logic [1:0] state, byte_cnt;
  logic [PC_BITS-1:0] addr, last_addr;
  logic [XLEN-1:0] word, word_next;
  logic xfer;
  assign xfer = in_valid & in_ready;
  assign word_next = {in_byte, word[XLEN-1:8]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
      cpu_rst <= 1'b1;
      in_ready <= 1'b0;
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
      byte_cnt <= '0;
      addr <= '0;
      last_addr <= '0;
      word <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR: begin
          in_ready <= 1'b1;
          if (xfer) begin
            if ({24'd0, in_byte} > DEPTH) begin
              err <= 1'b1;
            end else begin
              err <= 1'b0;
              addr <= '0;
              byte_cnt <= '0;
              last_addr <= PC_BITS'(in_byte - 8'd1);
              state <= (in_byte == 8'd0) ? FILL : DATA;
              in_ready <= (in_byte != 8'd0);
            end
          end
        end
        DATA: begin
          // in_ready low here means the last word's write is on the bus this cycle
          if (!in_ready) begin
            if (addr == '0) begin
              state <= DONE;
              done <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= FILL;
              imem_we <= 1'b1;
              imem_waddr <= addr;
              imem_wdata <= '0;
              addr <= addr + 1'b1;
            end
          end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            word <= word_next;
            if (byte_cnt == 2'd3) begin
              imem_we <= 1'b1;
              imem_waddr <= addr;
              imem_wdata <= word_next;
              addr <= addr + 1'b1;
              if (addr == last_addr) in_ready <= 1'b0;
            end
          end
        end
        FILL: begin
          if (imem_we && imem_waddr == '1) begin
            state <= DONE;
            done <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            imem_we <= 1'b1;
            imem_waddr <= addr;
            imem_wdata <= '0;
            addr <= addr + 1'b1;
          end
        end
        default: begin
          if (load_start) begin
            state <= HDR;
            cpu_rst <= 1'b1;
            done <= 1'b0;
            in_ready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter XLEN, default 32: instruction word width; only 32 is supported.
REQ-002 Parameter PC_BITS, default 5: instruction-memory address width; DEPTH = 2**PC_BITS words.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  loader byte-stream byte valid.
REQ-006 in_byte  input  8  loader byte-stream data.
REQ-007 in_ready  output  1  loader can accept a byte; a byte transfers on a rising edge where in_valid and in_ready are both 1.
REQ-008 load_start  input  1  single-cycle request to start a new load; honoured only in DONE.
REQ-009 imem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-010 imem_waddr  output  PC_BITS  word address of the write.
REQ-011 imem_wdata  output  XLEN  word data of the write.
REQ-012 cpu_rst  output  1  holds the CPU in reset; active-high.
REQ-013 done  output  1  load complete, CPU released.
REQ-014 err  output  1  sticky header-error flag.

Function
REQ-015 Stream format: one header byte N (number of words), then N words of 4 bytes each, least-significant byte first.
REQ-016 The FSM SHALL have these states: HDR, DATA, FILL, DONE.
REQ-017 In HDR, in_ready = 1. On a header transfer: if N <= DEPTH, go to DATA (N > 0) or FILL (N = 0), set the word address to 0, and clear err. If N > DEPTH, set err = 1, stay in HDR, and write nothing.
REQ-018 In DATA, in_ready = 1. A 2-bit byte counter assembles the word; bytes with in_valid low neither advance the counter nor change the word.
REQ-019 Write timing: on the transfer of byte 3 of a word, imem_we = 1 on the following cycle for exactly one cycle, with imem_waddr = current address and imem_wdata = the assembled word.
REQ-020 The write address SHALL increment by 1 after each write, wrapping modulo DEPTH. N = DEPTH SHALL therefore fill every address without an out-of-range write.
REQ-021 The write of word N-1 ends DATA: next state is FILL, or DONE if N = DEPTH. in_ready SHALL drop on the cycle after the last byte is transferred.
REQ-022 In FILL, in_ready = 0. The loader SHALL write 0x00000000 at one address per cycle, from N through DEPTH-1 inclusive, then go to DONE. The program is thus always terminated by zero instructions.
REQ-023 cpu_rst = 1 in HDR, DATA and FILL. It SHALL be 0 only in DONE and SHALL fall on the same edge that done rises.
REQ-024 In DONE, in_ready = 0 and incoming bytes are ignored. A load_start in DONE SHALL return the FSM to HDR on the next edge, with cpu_rst = 1 and done = 0 from that edge.
REQ-025 load_start outside DONE SHALL have no effect.
REQ-026 imem_we SHALL never be 1 in HDR or DONE, except for the final DATA/FILL write that completes on the edge entering DONE.
REQ-027 All outputs SHALL be registered; no combinational path from in_valid, in_byte or load_start to any output.

Reset
REQ-028 While rst = 1 at a rising edge, the next values SHALL be: state HDR, cpu_rst = 1, in_ready = 0, imem_we = 0, imem_waddr = 0, imem_wdata = 0, done = 0, err = 0, byte counter 0.
REQ-029 in_ready SHALL rise on the first edge after rst deasserts.
REQ-030 Reset mid-load (DATA or FILL) SHALL discard the partial word and the remaining fill. The next header restarts at address 0.
REQ-031 Reset in DONE SHALL reassert cpu_rst on the same edge.

Verification
REQ-032 Basic load, PC_BITS = 5: stream 02, 13 00 10 00, 93 00 20 00 -> writes addr0 = 0x00100013 and addr1 = 0x00200093, then addr2..31 = 0 on 30 consecutive cycles. done rises and cpu_rst falls on the edge after the addr31 write.
REQ-033 Stalled stream: same bytes with in_valid low for 1-3 cycles between bytes -> an identical write sequence, and no extra writes.
REQ-034 Empty program: header 00 -> 32 zero writes to addr0..31 on consecutive cycles, then done = 1.
REQ-035 Bad header: header 0x28 (40 > 32) -> err = 1, no imem_we, in_ready = 1, cpu_rst = 1. A following valid header 01 plus one word clears err and loads normally.
REQ-036 Reset mid-word: header 02, bytes 13 00, then rst for 1 cycle -> no write issued. A subsequent full stream writes from addr0 with correct data.
REQ-037 Reload: in DONE, pulse load_start -> on the next edge cpu_rst = 1, done = 0, in_ready = 1. A second program then overwrites addr0 onward.
